seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
Parametrised sequential shift-and-add multiplier; generational successor to the flat 8x8 array multiplier. Computes a WIDTH x WIDTH product in WIDTH iterations of one shared adder, trading latency for area. Supports unsigned and two's-complement signed modes, with a start/busy/done handshake. Sits behind the operand registers in the lab datapath and feeds the product display.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; captured with start
op_a  input  WIDTH  multiplicand; captured with start
op_b  input  WIDTH  multiplier; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse; product valid
product  output  2*WIDTH  result; holds until next done

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, busy=0, done=0, product=0, counter=0, internal accumulators=0. Reset mid-operation aborts; no done is issued for the aborted job.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. If start==1 at the edge: capture |op_a| and |op_b| (magnitude when signed_mode=1 and MSB=1, else raw), sign flag = signed_mode & (op_a[MSB] ^ op_b[MSB]); clear accumulator high half; load multiplier magnitude into the low half; counter=0; go to RUN.
- RUN: each edge: if acc_low[0]==1, high half <= high half + multiplicand (WIDTH+1-bit sum, carry kept); whole {carry, high, low} shifts right 1; counter++. After the WIDTH-th iteration (counter==WIDTH-1 at the edge), go to DONE.
- DONE (one cycle): product <= sign ? two's-complement negation of accumulator : accumulator; done=1; next edge returns to IDLE.
- Latency: start sampled at edge E0 -> done high and product valid in the cycle following edge E0+WIDTH+1. Throughput: one job per WIDTH+2 cycles; start may be reasserted in the IDLE cycle following done.
- busy=1 in RUN and DONE. start while busy is ignored (no queuing, no corruption).
- Signed -2^(WIDTH-1) magnitude (2^(WIDTH-1)) fits in WIDTH unsigned bits; no overflow is possible in 2*WIDTH bits.
- Zero operand: still WIDTH iterations; product=0, sign suppressed (never negative zero issue, since negation of 0 is 0).
- product changes only at DONE or reset; op_a/op_b/signed_mode changes after capture have no effect.
- done and start asserted in the same cycle: impossible by construction (DONE state ignores start; start sampled in next IDLE cycle).

Decomposition:
- Package mult_pkg: state enum {IDLE, RUN, DONE} as 2-bit logic type; a helper function for two's-complement magnitude.
- One sub-module: adder_nbit (parametrised WIDTH-bit ripple adder, carry out), the single shared adder of the datapath. FSM, counter and shift register stay in seq_multiplier.

Test Plan:
- WIDTH=8, unsigned, 13 x 11, start pulse -> done exactly 10 cycles after start edge, product=143 (0x008F), busy high 9 cycles.
- Unsigned 255 x 255 -> product=65025 (0xFE01); signed 255 x 255 (-1 x -1) -> 0x0001.
- Signed -3 (0xFD) x 5 -> 0xFFF1; signed -128 (0x80) x -128 -> 0x4000; signed -128 x 127 -> 0xC080.
- 0 x 200 unsigned and 0 x -7 signed -> product=0x0000, done after same latency.
- start re-pulsed with new operands (7 x 9) mid-RUN of 13 x 11 -> ignored, product=143; next start after done yields 63.
- reset=0 during RUN at cycle 4 -> busy=0, product=0, no done pulse; subsequent 6 x 7 completes with 42.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand supported; callers truncate the helper result to their own width.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Parametrised ripple-carry adder; the single shared adder of the multiplier datapath.
module adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH shift-and-add multiplier, one adder pass per cycle, signed or unsigned
// operands handled as magnitudes with the sign re-applied to the finished product.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int P_W   = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               sign_q, sign_d;
  logic [P_W-1:0]     product_q, product_d;
  logic               done_q, done_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [P_W-1:0]     acc;

  assign neg_a = signed_mode & op_a[WIDTH-1];
  assign neg_b = signed_mode & op_b[WIDTH-1];
  assign mag_a = WIDTH'(twos_mag(MAX_W'(op_a), neg_a));
  assign mag_b = WIDTH'(twos_mag(MAX_W'(op_b), neg_b));

  assign addend = lo_q[0] ? mcand_q : '0;
  assign acc    = {hi_q, lo_q};

  adder_nbit #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    sign_d    = sign_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          lo_d    = mag_b;
          hi_d    = '0;
          cnt_d   = '0;
          sign_d  = neg_a ^ neg_b;
          state_d = RUN;
        end
      end
      RUN: begin
        // {carry, sum, low} shifted right by one: the carry becomes the new high MSB.
        hi_d  = {add_cout, add_sum[WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = sign_q ? (~acc + P_W'(1)) : acc;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = done_q;
  assign product = product_q;

endmodule
